// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store port: word-addressed data RAM behind
// valid/ready request and response channels, with programmable wait states and range errors.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o
);

  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned AddrExtW = ADDR_W + 1;
  localparam logic [CntW-1:0]    CntLoad  = (LATENCY > 0) ? CntW'(LATENCY - 1) : '0;
  localparam logic [ADDR_W:0]    DepthExt = AddrExtW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                in_range;
  logic [IdxW-1:0]     idx;

  // Range check at full address width so high address bits never alias into the array.
  always_comb begin
    in_range    = {1'b0, req_addr_i} < DepthExt;
    idx         = req_addr_i[IdxW-1:0];
    req_ready_o = (state_q == StIdle) && !rst_i;
    accept      = req_valid_i && req_ready_o;
  end

  // Stores commit at the accepting edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && req_we_i && in_range) begin
      mem_q[idx] <= req_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            resp_err_q   <= !in_range;
            resp_rdata_q <= (in_range && !req_we_i) ? mem_q[idx] : '0;
            if (LATENCY == 0) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntLoad;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule
